// File: rtl/savestate_controller_if.sv
// Savestate controller signal bundle: host requests/status, CPU savestate bus, host save/load streams.
// master = controller side, slave = host/CPU side.
interface savestate_controller_if;
  logic        save_req;
  logic        load_req;
  logic        busy;
  logic        done;
  logic        error;
  logic        ss_halt;
  logic        ss_ready;
  logic [7:0]  ss_bus_addr;
  logic [31:0] ss_bus_in;
  logic        ss_bus_wren;
  logic        ss_bus_reset;
  logic [31:0] ss_bus_out;
  logic [31:0] save_data;
  logic        save_valid;
  logic        save_ready;
  logic [31:0] load_data;
  logic        load_valid;
  logic        load_ready;

  modport master (
    input  save_req, load_req, ss_ready, ss_bus_out, save_ready, load_data, load_valid,
    output busy, done, error, ss_halt, ss_bus_addr, ss_bus_in, ss_bus_wren, ss_bus_reset,
           save_data, save_valid, load_ready
  );

  modport slave (
    output save_req, load_req, ss_ready, ss_bus_out, save_ready, load_data, load_valid,
    input  busy, done, error, ss_halt, ss_bus_addr, ss_bus_in, ss_bus_wren, ss_bus_reset,
           save_data, save_valid, load_ready
  );
endinterface

// File: rtl/savestate_controller.sv
// Savestate initiator: halts the core, streams NUM_WORDS words out (SAVE) or in (LOAD); SS_CHECKSUM_EN adds a checksum word.
// Save path 3 cycles/word min, stalls in RD_PUSH on !save_ready; load path waits in WR_WAIT for load_valid.
module savestate_controller #(
  parameter int NUM_WORDS = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  savestate_controller_if.master ss
);

  localparam logic [7:0] LAST = 8'(NUM_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HALT, S_RD_ADDR, S_RD_CAPT, S_RD_PUSH,
    S_WR_RST, S_WR_WAIT, S_WR_STB, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic        is_save_q, is_save_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] wdata_q, wdata_d;
  logic        last_word;

`ifdef SS_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic        ck_q, ck_d;
  logic        err_q, err_d;
`endif

  assign last_word = (addr_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      is_save_q <= 1'b0;
      addr_q    <= '0;
      sdata_q   <= '0;
      wdata_q   <= '0;
`ifdef SS_CHECKSUM_EN
      sum_q     <= '0;
      ck_q      <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      is_save_q <= is_save_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      wdata_q   <= wdata_d;
`ifdef SS_CHECKSUM_EN
      sum_q     <= sum_d;
      ck_q      <= ck_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    is_save_d = is_save_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    wdata_d   = wdata_q;
`ifdef SS_CHECKSUM_EN
    sum_d     = sum_q;
    ck_d      = ck_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // save_req has priority when both arrive together
        if (ss.save_req || ss.load_req) begin
          state_d   = S_HALT;
          is_save_d = ss.save_req;
`ifdef SS_CHECKSUM_EN
          sum_d     = '0;
          ck_d      = 1'b0;
          err_d     = 1'b0;
`endif
        end
      end
      S_HALT: begin
        if (ss.ss_ready) begin
          state_d = is_save_q ? S_RD_ADDR : S_WR_RST;
        end
      end
      S_RD_ADDR: state_d = S_RD_CAPT;
      S_RD_CAPT: begin
        sdata_d = ss.ss_bus_out;
`ifdef SS_CHECKSUM_EN
        sum_d   = sum_q + ss.ss_bus_out;
`endif
        state_d = S_RD_PUSH;
      end
      S_RD_PUSH: begin
        if (ss.save_ready) begin
`ifdef SS_CHECKSUM_EN
          // checksum word reuses RD_PUSH with the address parked on the last word
          if (ck_q) begin
            state_d = S_FIN;
          end else if (last_word) begin
            ck_d    = 1'b1;
            sdata_d = sum_q;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = S_RD_ADDR;
          end
`else
          if (last_word) begin
            state_d = S_FIN;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = S_RD_ADDR;
          end
`endif
        end
      end
      S_WR_RST: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (ss.load_valid) begin
`ifdef SS_CHECKSUM_EN
          if (ck_q) begin
            err_d   = err_q | (ss.load_data != sum_q);
            state_d = S_FIN;
          end else begin
            wdata_d = ss.load_data;
            sum_d   = sum_q + ss.load_data;
            state_d = S_WR_STB;
          end
`else
          wdata_d = ss.load_data;
          state_d = S_WR_STB;
`endif
        end
      end
      S_WR_STB: begin
        if (last_word) begin
`ifdef SS_CHECKSUM_EN
          ck_d    = 1'b1;
          state_d = S_WR_WAIT;
`else
          state_d = S_FIN;
`endif
        end else begin
          addr_d  = addr_q + 8'd1;
          state_d = S_WR_WAIT;
        end
      end
      S_FIN: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ss.busy         = (state_q != S_IDLE);
    ss.ss_halt      = (state_q != S_IDLE);
    ss.done         = (state_q == S_FIN);
    ss.save_valid   = (state_q == S_RD_PUSH);
    ss.load_ready   = (state_q == S_WR_WAIT);
    ss.ss_bus_wren  = (state_q == S_WR_STB);
    ss.ss_bus_reset = (state_q == S_WR_RST);
    ss.ss_bus_addr  = addr_q;
    ss.ss_bus_in    = wdata_q;
    ss.save_data    = sdata_q;
`ifdef SS_CHECKSUM_EN
    ss.error        = err_q;
`else
    ss.error        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_savestate_controller.sv
// Bench for savestate_controller (NUM_WORDS=4): vector table of SAVE/LOAD transfers with a scoreboard,
// plus a hand-written reset-mid-LOAD sequence. Checksum vectors appear when SS_CHECKSUM_EN is defined.
module tb_savestate_controller;
  localparam int NW = 4;
`ifdef SS_CHECKSUM_EN
  localparam int CKW = 1;
`else
  localparam int CKW = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  savestate_controller_if sif();
  savestate_controller #(.NUM_WORDS(NW)) dut (.clk(clk), .reset_n(reset_n), .ss(sif));

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int save_cnt = 0;
  int wren_cnt = 0;
  int rst_cnt = 0;
  int act_cnt = 0;
  int rst_at_wren = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] mem [0:255];
  logic [31:0] ld_w [0:NW];
  logic [31:0] exp_save_q [$];
  logic [39:0] exp_wr_q [$];
  bit xfer_end;

  typedef struct {
    bit save; bit load; bit busy_load; bit rdy_tog;
    int halt_dly; int gap;
    logic [NW-1:0][31:0] w;
    bit ck_bad;
    int exp_save; int exp_wren; int exp_rst; bit exp_err; int exp_lat;
  } vec_t;

  vec_t vt [0:8];
  int   num_vec;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(bit s, bit l, bit bl, bit rt, int hd, int gp,
                               logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3,
                               bit cb, int es, int ew, int er, bit ee, int el);
    vec_t v;
    v.save = s; v.load = l; v.busy_load = bl; v.rdy_tog = rt;
    v.halt_dly = hd; v.gap = gp;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.ck_bad = cb;
    v.exp_save = es; v.exp_wren = ew; v.exp_rst = er; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  // CPU model: read data appears one cycle after the address
  always @(posedge clk) sif.ss_bus_out <= mem[sif.ss_bus_addr];

  always @(negedge clk) begin
    if (sif.save_valid && prev_stall) chk("save_hold", sif.save_data, prev_data);
    prev_stall <= sif.save_valid && !sif.save_ready;
    prev_data  <= sif.save_data;
    if (sif.save_valid && sif.save_ready) begin
      save_cnt <= save_cnt + 1;
      if (exp_save_q.size() == 0) chk("save_unexpected", exp_save_q.size(), 1);
      else chk("save_data", sif.save_data, exp_save_q.pop_front());
    end
    if (sif.ss_bus_wren) begin
      wren_cnt <= wren_cnt + 1;
      chk("wren_rst_excl", sif.ss_bus_reset, 0);
      if (exp_wr_q.size() == 0) chk("wren_unexpected", exp_wr_q.size(), 1);
      else chk("wren_addr_data", {sif.ss_bus_addr, sif.ss_bus_in}, exp_wr_q.pop_front());
    end
    if (sif.ss_bus_reset) begin
      rst_cnt     <= rst_cnt + 1;
      rst_at_wren <= wren_cnt;
    end
    if (sif.done) done_cnt <= done_cnt + 1;
    if (sif.save_valid || sif.ss_bus_wren || sif.ss_bus_reset || sif.load_ready) act_cnt <= act_cnt + 1;
  end

  task automatic drive_load(input int n, input int gap);
    int t;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      repeat (gap) begin @(posedge clk); #1; end
      sif.load_valid = 1'b1;
      sif.load_data  = ld_w[i];
      t = 0;
      do begin @(negedge clk); t++; end while (!sif.load_ready && t < 500);
      if (!sif.load_ready) chk("load_ready_timeout", t, 0);
      @(posedge clk); #1;
      sif.load_valid = 1'b0;
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int d0, s0, w0, r0, a0, c;
    logic [31:0] sum;
    d0 = done_cnt; s0 = save_cnt; w0 = wren_cnt; r0 = rst_cnt;
    sum = '0;
    for (int i = 0; i < NW; i++) begin
      mem[i]  = v.w[i];
      ld_w[i] = v.w[i];
      sum     = sum + v.w[i];
    end
    ld_w[NW] = sum + {31'b0, v.ck_bad};
    if (v.save) begin
      for (int i = 0; i < NW; i++) exp_save_q.push_back(v.w[i]);
`ifdef SS_CHECKSUM_EN
      exp_save_q.push_back(sum);
`endif
    end else if (v.load) begin
      for (int i = 0; i < NW; i++) exp_wr_q.push_back({8'(i), v.w[i]});
    end
    sif.ss_ready   = (v.halt_dly == 0);
    sif.save_ready = !v.rdy_tog;
    xfer_end = 1'b0;

    @(posedge clk); #1;
    sif.save_req = v.save;
    sif.load_req = v.load;
    @(posedge clk); #1;
    sif.save_req = 1'b0;
    sif.load_req = v.busy_load;
    @(negedge clk);
    chk($sformatf("v%0d_busy_halt_rise", k), {sif.busy, sif.ss_halt}, 2'b11);
    @(posedge clk); #1;
    sif.load_req = 1'b0;

    if (v.halt_dly > 0) begin
      a0 = act_cnt;
      repeat (v.halt_dly) @(posedge clk);
      chk($sformatf("v%0d_no_bus_while_halt", k), act_cnt - a0, 0);
      @(negedge clk);
      chk($sformatf("v%0d_halt_held", k), sif.ss_halt, 1);
      @(posedge clk); #1;
      sif.ss_ready = 1'b1;
      c = 0;
      do begin @(negedge clk); c++; end while (!(sif.save_valid || sif.ss_bus_reset) && c < 200);
      chk($sformatf("v%0d_first_access_lat", k), c, v.exp_lat);
    end

    fork
      begin
        if (v.load && !v.save) drive_load(NW + CKW, v.gap);
      end
      begin
        if (v.rdy_tog) begin
          while (!xfer_end) begin @(posedge clk); #1; sif.save_ready = ~sif.save_ready; end
        end
      end
      begin
        int t;
        t = 0;
        while (done_cnt == d0 && t < 3000) begin @(posedge clk); t++; end
        xfer_end = 1'b1;
        chk($sformatf("v%0d_done_seen", k), done_cnt != d0, 1);
      end
    join

    sif.save_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk($sformatf("v%0d_done_count", k), done_cnt - d0, 1);
    chk($sformatf("v%0d_save_words", k), save_cnt - s0, v.exp_save);
    chk($sformatf("v%0d_wren_count", k), wren_cnt - w0, v.exp_wren);
    chk($sformatf("v%0d_rst_count", k), rst_cnt - r0, v.exp_rst);
    if (v.exp_rst > 0) chk($sformatf("v%0d_rst_before_wren", k), rst_at_wren, w0);
    chk($sformatf("v%0d_queues_empty", k), exp_save_q.size() + exp_wr_q.size(), 0);
    chk($sformatf("v%0d_idle_after", k), {sif.busy, sif.ss_halt, sif.ss_bus_addr}, 0);
    chk($sformatf("v%0d_error", k), sif.error, v.exp_err);
    exp_save_q.delete();
    exp_wr_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, w0, t;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
    sif.save_req = 1'b0; sif.load_req = 1'b0; sif.ss_ready = 1'b0;
    sif.save_ready = 1'b1; sif.load_valid = 1'b0; sif.load_data = '0;
    reset_n = 1'b0;

    vt[0] = mkv(1, 0, 0, 0, 0,  0, 32'h1000, 32'h1001, 32'h1002, 32'h1003, 0, NW + CKW, 0, 0, 0, 0);
    vt[1] = mkv(1, 0, 0, 1, 0,  0, 32'hCAFE0001, 32'hCAFE0002, 32'hBEEF0003, 32'h00000004, 0, NW + CKW, 0, 0, 0, 0);
    vt[2] = mkv(0, 1, 0, 0, 0,  2, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 0, 0, NW, 1, 0, 0);
    vt[3] = mkv(1, 1, 1, 0, 0,  0, 32'h2000, 32'h2001, 32'h2002, 32'h2003, 0, NW + CKW, 0, 0, 0, 0);
    vt[4] = mkv(1, 0, 0, 0, 50, 0, 32'h3000, 32'h3001, 32'h3002, 32'h3003, 0, NW + CKW, 0, 0, 0, 4);
    vt[5] = mkv(0, 1, 0, 0, 10, 1, 32'h5, 32'h6, 32'h7, 32'h8, 0, 0, NW, 1, 0, 2);
    num_vec = 6;
`ifdef SS_CHECKSUM_EN
    vt[6] = mkv(1, 0, 0, 0, 0, 0, 32'd1, 32'd2, 32'd3, 32'd4, 0, NW + 1, 0, 0, 0, 0);
    vt[7] = mkv(0, 1, 0, 0, 0, 0, 32'd1, 32'd2, 32'd3, 32'd4, 1, 0, NW, 1, 1, 0);
    vt[8] = mkv(0, 1, 0, 0, 0, 1, 32'd9, 32'd8, 32'd7, 32'd6, 0, 0, NW, 1, 0, 0);
    num_vec = 9;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl_outputs", {sif.busy, sif.done, sif.error, sif.ss_halt, sif.ss_bus_wren,
                               sif.ss_bus_reset, sif.save_valid, sif.load_ready}, 0);
    chk("reset_addr", sif.ss_bus_addr, 0);
    chk("reset_data", {sif.save_data, sif.ss_bus_in}, 0);
    reset_n = 1'b1;

    for (int k = 0; k < num_vec; k++) run_vec(k, vt[k]);

    // reset in the middle of a LOAD, after two words have been written
    d0 = done_cnt; w0 = wren_cnt;
    sif.ss_ready = 1'b1;
    ld_w[0] = 32'h11; ld_w[1] = 32'h22;
    exp_wr_q.push_back({8'd0, 32'h11});
    exp_wr_q.push_back({8'd1, 32'h22});
    @(posedge clk); #1;
    sif.load_req = 1'b1;
    @(posedge clk); #1;
    sif.load_req = 1'b0;
    drive_load(2, 0);
    t = 0;
    while (wren_cnt - w0 < 2 && t < 100) begin @(posedge clk); t++; end
    chk("rst_mid_two_writes", wren_cnt - w0, 2);
    #1;
    chk("rst_mid_in_progress", {sif.busy, sif.load_ready}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_ctrl_zero", {sif.busy, sif.done, sif.error, sif.ss_halt, sif.ss_bus_wren,
                              sif.ss_bus_reset, sif.save_valid, sif.load_ready}, 0);
    chk("rst_mid_addr_zero", sif.ss_bus_addr, 0);
    chk("rst_mid_data_zero", {sif.save_data, sif.ss_bus_in}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_idle", {sif.busy, sif.ss_halt}, 0);
    chk("rst_mid_queue", exp_wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
